// File: rtl/clock_set_ctrl.sv
// Mode/sequencing controller for the hour/minute/second counters: run-mode tick carries, set-mode field steering.
// Optional set-mode inactivity timeout is built when CLOCK_CTRL_TIMEOUT_EN is defined.
module clock_set_ctrl #(
   parameter int TIMEOUT_TICKS = 10
) (
   input  logic       clk,
   input  logic       clear,
   input  logic       tick,
   input  logic       mode_btn,
   input  logic       inc_btn,
   input  logic [5:0] sec_digits,
   input  logic [5:0] min_digits,
   output logic       sec_inc,
   output logic       min_inc,
   output logic       hour_inc,
   output logic       sec_clr,
   output logic       keep,
   output logic [1:0] sel,
   output logic       blink
);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      SET_HR  = 2'd1,
      SET_MIN = 2'd2,
      SET_SEC = 2'd3
   } state_t;

   state_t state;
   state_t state_next;

   logic mode_q;
   logic inc_q;
   logic mode_edge;
   logic inc_edge;

   logic sec_inc_next;
   logic min_inc_next;
   logic hour_inc_next;
   logic sec_clr_next;
   logic keep_next;
   logic blink_next;

`ifdef CLOCK_CTRL_TIMEOUT_EN
   localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_TICKS);
   logic [7:0] idle_ticks;
   logic [7:0] idle_ticks_next;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_TICKS;
`endif

   // Edge history resets high so a button held through clear must be released first.
   assign mode_edge = mode_btn & ~mode_q;
   assign inc_edge  = inc_btn & ~inc_q;

   always_comb begin
      state_next    = state;
      sec_inc_next  = 1'b0;
      min_inc_next  = 1'b0;
      hour_inc_next = 1'b0;
      sec_clr_next  = 1'b0;

      case (state)
         RUN: begin
            if (tick) begin
               sec_inc_next  = 1'b1;
               min_inc_next  = (sec_digits == 6'd59);
               hour_inc_next = (sec_digits == 6'd59) && (min_digits == 6'd59);
            end
            if (mode_edge) state_next = SET_HR;
         end
         SET_HR: begin
            hour_inc_next = inc_edge;
            if (mode_edge) state_next = SET_MIN;
         end
         SET_MIN: begin
            min_inc_next = inc_edge;
            if (mode_edge) state_next = SET_SEC;
         end
         SET_SEC: begin
            sec_clr_next = inc_edge;
            if (mode_edge) state_next = RUN;
         end
      endcase

`ifdef CLOCK_CTRL_TIMEOUT_EN
      // Any button edge restarts the idle count; a mode edge also outranks the timeout.
      idle_ticks_next = idle_ticks;
      if (state == RUN) begin
         idle_ticks_next = 8'd0;
      end else if (mode_edge || inc_edge) begin
         idle_ticks_next = 8'd0;
      end else if (tick) begin
         if (idle_ticks + 8'd1 == TIMEOUT_LIMIT) begin
            state_next      = RUN;
            idle_ticks_next = 8'd0;
         end else begin
            idle_ticks_next = idle_ticks + 8'd1;
         end
      end
      if (state_next == RUN) idle_ticks_next = 8'd0;
`endif

      keep_next = (state_next != RUN);

      if (state_next != state) begin
         blink_next = 1'b0;
      end else if (state != RUN && tick) begin
         blink_next = ~blink;
      end else begin
         blink_next = blink;
      end
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         state    <= RUN;
         mode_q   <= 1'b1;
         inc_q    <= 1'b1;
         sec_inc  <= 1'b0;
         min_inc  <= 1'b0;
         hour_inc <= 1'b0;
         sec_clr  <= 1'b0;
         keep     <= 1'b0;
         blink    <= 1'b0;
      end else begin
         state    <= state_next;
         mode_q   <= mode_btn;
         inc_q    <= inc_btn;
         sec_inc  <= sec_inc_next;
         min_inc  <= min_inc_next;
         hour_inc <= hour_inc_next;
         sec_clr  <= sec_clr_next;
         keep     <= keep_next;
         blink    <= blink_next;
      end
   end

`ifdef CLOCK_CTRL_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (clear) begin
         idle_ticks <= 8'd0;
      end else begin
         idle_ticks <= idle_ticks_next;
      end
   end
`endif

   assign sel = state;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: directed vectors plus a per-cycle behavioural model comparison.
module tb_clock_set_ctrl;

`ifdef CLOCK_CTRL_TIMEOUT_EN
   localparam int TO_TICKS = 3;
`else
   localparam int TO_TICKS = 10;
`endif

   logic       clk = 1'b0;
   logic       clear;
   logic       tick;
   logic       mode_btn;
   logic       inc_btn;
   logic [5:0] sec_digits;
   logic [5:0] min_digits;
   logic       sec_inc;
   logic       min_inc;
   logic       hour_inc;
   logic       sec_clr;
   logic       keep;
   logic [1:0] sel;
   logic       blink;

   int compared   = 0;
   int mismatched = 0;

   int n_sec_inc  = 0;
   int n_min_inc  = 0;
   int n_hour_inc = 0;
   int n_sec_clr  = 0;

   always #5 clk = ~clk;

   clock_set_ctrl #(.TIMEOUT_TICKS(TO_TICKS)) dut (
      .clk        (clk),
      .clear      (clear),
      .tick       (tick),
      .mode_btn   (mode_btn),
      .inc_btn    (inc_btn),
      .sec_digits (sec_digits),
      .min_digits (min_digits),
      .sec_inc    (sec_inc),
      .min_inc    (min_inc),
      .hour_inc   (hour_inc),
      .sec_clr    (sec_clr),
      .keep       (keep),
      .sel        (sel),
      .blink      (blink)
   );

   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Behavioural model: field index counts mode presses modulo 4; outputs follow one cycle later.
   int m_field = 0;
   int m_idle  = 0;
   bit m_blink = 0;
   bit m_mode_q = 1;
   bit m_inc_q = 1;
   bit m_valid = 0;
   bit e_sec_inc = 0, e_min_inc = 0, e_hour_inc = 0, e_sec_clr = 0;

   always @(posedge clk) begin
      bit me, ie;
      int nxt;
      if (clear) begin
         m_field = 0; m_idle = 0; m_blink = 0; m_mode_q = 1; m_inc_q = 1; m_valid = 1;
         e_sec_inc = 0; e_min_inc = 0; e_hour_inc = 0; e_sec_clr = 0;
      end else if (m_valid) begin
         me = mode_btn && !m_mode_q;
         ie = inc_btn && !m_inc_q;
         e_sec_inc = 0; e_min_inc = 0; e_hour_inc = 0; e_sec_clr = 0;
         if (m_field == 0 && tick) begin
            e_sec_inc  = 1;
            e_min_inc  = (int'(sec_digits) == 59);
            e_hour_inc = (int'(sec_digits) == 59) && (int'(min_digits) == 59);
         end
         if (ie) begin
            if (m_field == 1) e_hour_inc = 1;
            if (m_field == 2) e_min_inc = 1;
            if (m_field == 3) e_sec_clr = 1;
         end
         nxt = me ? (m_field + 1) % 4 : m_field;
`ifdef CLOCK_CTRL_TIMEOUT_EN
         if (m_field != 0) begin
            if (me || ie) m_idle = 0;
            else if (tick) begin
               m_idle = m_idle + 1;
               if (m_idle == TO_TICKS) begin
                  nxt = 0;
                  m_idle = 0;
               end
            end
         end
         if (nxt == 0) m_idle = 0;
`endif
         if (nxt != m_field) m_blink = 0;
         else if (m_field != 0 && tick) m_blink = !m_blink;
         m_field  = nxt;
         m_mode_q = mode_btn;
         m_inc_q  = inc_btn;
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         checkOutput("cyc_sel", 8'(sel), 8'(m_field));
         checkOutput("cyc_keep", 8'(keep), 8'(m_field != 0));
         checkOutput("cyc_blink", 8'(blink), 8'(m_blink));
         checkOutput("cyc_sec_inc", 8'(sec_inc), 8'(e_sec_inc));
         checkOutput("cyc_min_inc", 8'(min_inc), 8'(e_min_inc));
         checkOutput("cyc_hour_inc", 8'(hour_inc), 8'(e_hour_inc));
         checkOutput("cyc_sec_clr", 8'(sec_clr), 8'(e_sec_clr));
      end
      n_sec_inc  += int'(sec_inc === 1'b1);
      n_min_inc  += int'(min_inc === 1'b1);
      n_hour_inc += int'(hour_inc === 1'b1);
      n_sec_clr  += int'(sec_clr === 1'b1);
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic applyStimulus(input bit t, input bit m, input bit i);
      tick = t;
      mode_btn = m;
      inc_btn = i;
      cyc(1);
   endtask

   task automatic pressMode(input logic [1:0] exp_sel, input string name);
      applyStimulus(0, 1, 0);
      checkOutput(name, 8'(sel), 8'(exp_sel));
      applyStimulus(0, 0, 0);
   endtask

   task automatic printSummary();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
   endtask

   initial begin
      int base;
      clear = 1; tick = 0; mode_btn = 0; inc_btn = 0; sec_digits = 0; min_digits = 0;
      cyc(2);
      clear = 0;
      checkOutput("rst_sel", 8'(sel), 8'd0);
      checkOutput("rst_keep", 8'(keep), 8'd0);
      checkOutput("rst_blink", 8'(blink), 8'd0);
      checkOutput("rst_sec_inc", 8'(sec_inc), 8'd0);
      checkOutput("rst_sec_clr", 8'(sec_clr), 8'd0);

      sec_digits = 6'd10;
      base = n_sec_inc;
      repeat (3) begin
         applyStimulus(1, 0, 0);
         checkOutput("tick_sec_inc", 8'(sec_inc), 8'd1);
         checkOutput("tick_min_inc", 8'(min_inc), 8'd0);
         checkOutput("tick_hour_inc", 8'(hour_inc), 8'd0);
         applyStimulus(0, 0, 0);
         checkOutput("tick_width", 8'(sec_inc), 8'd0);
      end
      checkOutput("three_tick_count", 8'(n_sec_inc - base), 8'd3);

      sec_digits = 6'd59; min_digits = 6'd59;
      applyStimulus(1, 0, 0);
      checkOutput("carry_sec", 8'(sec_inc), 8'd1);
      checkOutput("carry_min", 8'(min_inc), 8'd1);
      checkOutput("carry_hour", 8'(hour_inc), 8'd1);
      applyStimulus(0, 0, 0);
      min_digits = 6'd12;
      applyStimulus(1, 0, 0);
      checkOutput("carry12_min", 8'(min_inc), 8'd1);
      checkOutput("carry12_hour", 8'(hour_inc), 8'd0);
      applyStimulus(0, 0, 0);

      pressMode(2'd1, "mode_step1");
      checkOutput("mode_keep1", 8'(keep), 8'd1);
      pressMode(2'd2, "mode_step2");
      min_digits = 6'd59;
      applyStimulus(1, 0, 0);
      checkOutput("setmin_blink1", 8'(blink), 8'd1);
      checkOutput("setmin_no_sec_inc", 8'(sec_inc), 8'd0);
      checkOutput("setmin_no_min_inc", 8'(min_inc), 8'd0);
      applyStimulus(0, 0, 0);
      applyStimulus(1, 0, 0);
      checkOutput("setmin_blink0", 8'(blink), 8'd0);
      applyStimulus(0, 0, 0);
      pressMode(2'd3, "mode_step3");
      checkOutput("mode_keep3", 8'(keep), 8'd1);
      pressMode(2'd0, "mode_step0");
      checkOutput("mode_keep0", 8'(keep), 8'd0);

      pressMode(2'd1, "field_hr");
      base = n_hour_inc;
      applyStimulus(0, 0, 1);
      applyStimulus(0, 0, 0);
      applyStimulus(0, 0, 1);
      applyStimulus(0, 0, 0);
      checkOutput("hr_two_presses", 8'(n_hour_inc - base), 8'd2);
      pressMode(2'd2, "field_min");
      pressMode(2'd3, "field_sec");
      base = n_sec_clr;
      applyStimulus(0, 0, 1);
      checkOutput("sec_clr_pulse", 8'(sec_clr), 8'd1);
      applyStimulus(0, 0, 0);
      checkOutput("sec_clr_one", 8'(n_sec_clr - base), 8'd1);
      base = n_sec_clr;
      repeat (20) applyStimulus(0, 0, 1);
      applyStimulus(0, 0, 0);
      checkOutput("held_btn_one_pulse", 8'(n_sec_clr - base), 8'd1);
      pressMode(2'd0, "field_back_run");

      sec_digits = 6'd10;
      applyStimulus(1, 1, 0);
      checkOutput("simul_sec_inc", 8'(sec_inc), 8'd1);
      checkOutput("simul_sel", 8'(sel), 8'd1);
      applyStimulus(0, 0, 0);
      pressMode(2'd2, "simul_to_min");
      pressMode(2'd3, "simul_to_sec");
      clear = 1;
      inc_btn = 1;
      cyc(1);
      checkOutput("clear_no_sec_clr", 8'(sec_clr), 8'd0);
      checkOutput("clear_sel", 8'(sel), 8'd0);
      clear = 0;
      applyStimulus(0, 0, 0);

      mode_btn = 1;
      clear = 1;
      cyc(2);
      clear = 0;
      cyc(3);
      checkOutput("held_reset_sel", 8'(sel), 8'd0);
      checkOutput("held_reset_keep", 8'(keep), 8'd0);
      applyStimulus(0, 0, 0);
      pressMode(2'd1, "after_held_sel");
      pressMode(2'd2, "after_held_2");
      pressMode(2'd3, "after_held_3");
      pressMode(2'd0, "after_held_0");

`ifdef CLOCK_CTRL_TIMEOUT_EN
      pressMode(2'd1, "to_hr");
      pressMode(2'd2, "to_min");
      applyStimulus(1, 0, 0);
      applyStimulus(0, 0, 0);
      applyStimulus(1, 0, 0);
      applyStimulus(0, 0, 0);
      checkOutput("to_before", 8'(sel), 8'd2);
      applyStimulus(1, 0, 0);
      checkOutput("to_fired", 8'(sel), 8'd0);
      checkOutput("to_no_sec_inc", 8'(sec_inc), 8'd0);
      applyStimulus(0, 0, 0);
      pressMode(2'd1, "to2_hr");
      pressMode(2'd2, "to2_min");
      applyStimulus(1, 0, 0);
      applyStimulus(0, 0, 0);
      applyStimulus(1, 0, 0);
      applyStimulus(0, 0, 0);
      applyStimulus(0, 0, 1);
      checkOutput("to2_min_inc", 8'(min_inc), 8'd1);
      applyStimulus(0, 0, 0);
      applyStimulus(1, 0, 0);
      applyStimulus(0, 0, 0);
      applyStimulus(1, 0, 0);
      applyStimulus(0, 0, 0);
      checkOutput("to2_restarted", 8'(sel), 8'd2);
      applyStimulus(1, 0, 0);
      checkOutput("to2_fired", 8'(sel), 8'd0);
      applyStimulus(0, 0, 0);
`endif

      cyc(2);
      printSummary();
      $finish;
   end

   initial begin
      #200000;
      mismatched++;
      $display("[TB] FAIL watchdog: time limit reached, sequence incomplete");
      printSummary();
      $finish;
   end

endmodule
